prm_oblgc_mask_accum: RTL and testbench
=======================================

# prm_oblgc_mask_accum

Parametrised, sequential successor to the fixed per-edge obstacle-logic check functions used for PRM roadmap pruning. It consumes a stream of occupied-voxel codes for one sensing frame. For each code it looks up a run-time loadable table that says which roadmap edges the voxel blocks. It ORs the looked-up rows into a per-frame edge mask and hands the finished mask to the planner over a valid/ready handshake. It replaces one hard-wired truth-table module per edge with a single table-driven block covering NUM_EDGES edges.

## Interface
- IDX_W, 15, width of a voxel code and table address; table depth is 2^IDX_W.
- NUM_EDGES, 32, number of edges (table row width, mask width).
- CNT_W, 16, width of the per-frame voxel counter.

- clk, input, 1, sole clock; all logic is on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cfg_we, input, 1, table write strobe.
- cfg_addr, input, IDX_W, table write address.
- cfg_data, input, NUM_EDGES, table row; bit e=1 means the voxel blocks edge e.
- cfg_err, output, 1, one-cycle pulse when a write is rejected.
- vox_valid, input, 1, voxel code valid.
- vox_ready, output, 1, block accepts a voxel code.
- vox_data, input, IDX_W, voxel code.
- vox_last, input, 1, final voxel of the frame.
- frame_abort, input, 1, discard the current frame.
- mask_valid, output, 1, result available.
- mask_ready, input, 1, planner consumes the result.
- mask_data, output, NUM_EDGES, OR of the table rows of all voxels in the frame.
- mask_count, output, CNT_W, number of voxels accepted in the frame; saturates at all-ones.

## Operation
- Table: single-port synchronous RAM, 2^IDX_W × NUM_EDGES, with 1-cycle read latency. It is not cleared by reset, and its content after power-up is undefined.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - vox_ready=1 and cfg writes are accepted.
  - An accepted beat (vox_valid&vox_ready) issues a table read and increments the counter.
  - If vox_last=0, go to ACCUM. If vox_last=1, go to DRAIN.
- ACCUM:
  - vox_ready=1.
  - Each accepted beat issues a read, and the previous read's row is ORed into the accumulator.
  - A beat with vox_last=1 goes to DRAIN.
- DRAIN:
  - vox_ready=0.
  - The final row is ORed in, then go to DONE.
- DONE:
  - mask_valid=1, and mask_data and mask_count are held stable.
  - On mask_valid&mask_ready, clear the accumulator and counter, then go to IDLE.
- cfg writes:
  - In IDLE, if cfg_we coincides with an accepted vox beat, the write is rejected.
  - In ACCUM, DRAIN or DONE, the write is rejected. The RAM is unchanged and cfg_err pulses the next cycle.
- frame_abort:
  - Only honoured in ACCUM and DRAIN, where it beats vox_last.
  - The accumulator, counter and any in-flight read are discarded, and the state returns to IDLE.
  - It is ignored in IDLE and DONE.
- Width and arithmetic:
  - The accumulator is a pure bitwise OR, so duplicate voxels are idempotent.
  - The counter increments per accepted beat and saturates at 2^CNT_W−1 without wrapping.
- Reset (asserted at any time):
  - State=IDLE; accumulator and counter 0.
  - Outputs: vox_ready=1 after release, mask_valid=0, mask_data=0, mask_count=0, cfg_err=0.
  - An in-progress frame is lost.

## Timing
- vox_ready is registered and depends only on state, never combinationally on vox_valid.
- Throughput: one voxel per cycle sustained in IDLE/ACCUM with no bubbles.
- Latency: if the vox_last beat is accepted at edge t, mask_valid rises after edge t+2.
- Handshake rules:
  - mask_data and mask_count must not change while mask_valid=1 and mask_ready=0.
  - After the mask handshake at edge t, vox_ready=1 from edge t+1.
- Table writes: a row written at edge t is visible to a lookup issued at edge t+1 or later.
- frame_abort: sampled at an edge in ACCUM/DRAIN; vox_ready=1 after that edge in IDLE.

## Test plan
- Basic frame:
  - Stimulus: load row[5]=0x0000_0003 and row[9]=0x8000_0000, then stream voxels 5, 9 (last).
  - Required: mask_data=0x8000_0003 and mask_count=2; mask_valid rises exactly 2 cycles after the last beat.
- Back-pressure and repeat:
  - Stimulus: hold mask_ready=0 for 10 cycles after mask_valid, then complete the handshake, then immediately run a second frame containing only voxel 5.
  - Required: outputs are stable during the wait; the second result is 0x0000_0003 with count 1, with no leakage from frame 1.
- Rejected write:
  - Stimulus: cfg_we to address 5 with data 0xFFFF_FFFF while in ACCUM.
  - Required: cfg_err pulses once, and a subsequent frame {5} yields 0x0000_0003.
- Abort:
  - Stimulus: stream 9, 5, then assert frame_abort; then send frame {5, last}.
  - Required: no mask_valid for the aborted frame; the next result is 0x0000_0003 with count 1.
- Saturation:
  - Stimulus: with CNT_W=4, send 20 voxels of code 0 where row[0]=0x1.
  - Required: mask_count=15 and mask_data=0x1.
- Async reset:
  - Stimulus: assert rst_n=0 mid-ACCUM between clock edges.
  - Required: mask_valid=0, mask_data=0 and mask_count=0 immediately; vox_ready=1 after release; the table still returns its previously loaded rows.

Source files
------------

// File: rtl/prm_oblgc_mask_accum.sv
// prm_oblgc_mask_accum
// Table-driven obstacle mask accumulator for PRM roadmap pruning.
// A stream of occupied-voxel codes for one sensing frame indexes a run-time
// loadable table (one row of NUM_EDGES blocked-edge bits per voxel). The
// rows are ORed into a per-frame edge mask, and a saturating counter tracks
// how many voxels arrived. The finished mask is offered to the planner over
// a valid/ready handshake.
//
// Pipeline per accepted voxel:
//   edge t   : table read issued, counter bumped, r_rd_vld set
//   edge t+1 : row ORed into r_acc
// After the last voxel, DRAIN waits for the final row to land and then
// spends one more edge confirming nothing is in flight. mask_valid
// therefore rises after edge t+2 when the last beat is accepted at edge t.
module prm_oblgc_mask_accum #(
  parameter int IDX_W     = 15,
  parameter int NUM_EDGES = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // table load port
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [NUM_EDGES-1:0] cfg_data,
  output logic                 cfg_err,
  // voxel stream
  input  logic                 vox_valid,
  output logic                 vox_ready,
  input  logic [IDX_W-1:0]     vox_data,
  input  logic                 vox_last,
  input  logic                 frame_abort,
  // result
  output logic                 mask_valid,
  input  logic                 mask_ready,
  output logic [NUM_EDGES-1:0] mask_data,
  output logic [CNT_W-1:0]     mask_count
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_vox_ready;
  logic                 r_mask_valid;
  logic                 r_cfg_err;
  logic                 r_rd_vld;
  logic [NUM_EDGES-1:0] r_rd_row;
  logic [NUM_EDGES-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;

  // Table storage; not reset, contents undefined until loaded.
  logic [NUM_EDGES-1:0] r_mem [DEPTH];

  logic                 w_vox_acc;
  logic                 w_cfg_acc;
  logic [CNT_W-1:0]     w_cnt_inc;

  // vox_ready is a registered function of state, so the accept term is
  // never a combinational loop back through vox_valid.
  assign w_vox_acc = vox_valid & r_vox_ready;

  // The table has one port: a write can only go in while idle and only
  // when no lookup is claiming the port on the same edge.
  assign w_cfg_acc = cfg_we & (r_state == S_IDLE) & ~w_vox_acc;

  // Counter sticks at all-ones instead of wrapping.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  assign vox_ready  = r_vox_ready;
  assign mask_valid = r_mask_valid;
  assign mask_data  = r_acc;
  assign mask_count = r_cnt;
  assign cfg_err    = r_cfg_err;

  // Single-port table: write when a load is accepted, otherwise serve the
  // lookup for an accepted voxel (the two are mutually exclusive).
  always_ff @(posedge clk) begin
    if (w_cfg_acc)
      r_mem[cfg_addr] <= cfg_data;
    else if (w_vox_acc)
      r_rd_row <= r_mem[vox_data];
  end

  // Rejected loads raise a one-cycle error flag on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cfg_err <= 1'b0;
    else
      r_cfg_err <= cfg_we & ~w_cfg_acc;
  end

  // Frame FSM with accumulator, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vox_ready  <= 1'b1;
      r_mask_valid <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Accumulator and counter are already clear on entry here.
          if (w_vox_acc) begin
            r_cnt    <= w_cnt_inc;
            r_rd_vld <= 1'b1;
            if (vox_last) begin
              r_state     <= S_DRAIN;
              r_vox_ready <= 1'b0;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end

        S_ACCUM: begin
          if (frame_abort) begin
            // Abort wins over any beat or last flag on this edge.
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_rd_vld <= 1'b0;
          end else begin
            if (r_rd_vld)
              r_acc <= r_acc | r_rd_row;
            r_rd_vld <= w_vox_acc;
            if (w_vox_acc) begin
              r_cnt <= w_cnt_inc;
              if (vox_last) begin
                r_state     <= S_DRAIN;
                r_vox_ready <= 1'b0;
              end
            end
          end
        end

        S_DRAIN: begin
          if (frame_abort) begin
            r_state     <= S_IDLE;
            r_vox_ready <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_rd_vld    <= 1'b0;
          end else if (r_rd_vld) begin
            // Final row lands here.
            r_acc    <= r_acc | r_rd_row;
            r_rd_vld <= 1'b0;
          end else begin
            r_state      <= S_DONE;
            r_mask_valid <= 1'b1;
          end
        end

        S_DONE: begin
          // Result held until the planner takes it; abort is ignored.
          if (mask_ready) begin
            r_state      <= S_IDLE;
            r_mask_valid <= 1'b0;
            r_vox_ready  <= 1'b1;
            r_acc        <= '0;
            r_cnt        <= '0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_vox_ready  <= 1'b1;
          r_mask_valid <= 1'b0;
          r_rd_vld     <= 1'b0;
          r_acc        <= '0;
          r_cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prm_oblgc_mask_accum.sv
// Directed bench for prm_oblgc_mask_accum; counter width reduced to 4 bits
// so saturation is reachable with a short frame.
module tb_prm_oblgc_mask_accum;

  localparam int IDX_W = 15;
  localparam int NE    = 32;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [NE-1:0]    cfg_data;
  logic             cfg_err;
  logic             vox_valid;
  logic             vox_ready;
  logic [IDX_W-1:0] vox_data;
  logic             vox_last;
  logic             frame_abort;
  logic             mask_valid;
  logic             mask_ready;
  logic [NE-1:0]    mask_data;
  logic [CW-1:0]    mask_count;

  int n_pass  = 0;
  int n_total = 0;

  prm_oblgc_mask_accum #(.IDX_W(IDX_W), .NUM_EDGES(NE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .vox_valid(vox_valid), .vox_ready(vox_ready), .vox_data(vox_data),
    .vox_last(vox_last), .frame_abort(frame_abort),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask_data(mask_data), .mask_count(mask_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] a, input logic [NE-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_beat(input logic [IDX_W-1:0] code, input logic last);
    vox_valid = 1'b1; vox_data = code; vox_last = last;
    tick();
    vox_valid = 1'b0; vox_last = 1'b0;
  endtask

  task automatic wait_mask(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mask_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic handshake();
    mask_ready = 1'b1;
    tick();
    mask_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_total++;
    if (mask_valid !== 1'b0 || mask_data !== '0 || mask_count !== '0 || cfg_err !== 1'b0) begin
      $display("FAIL reset_outputs: got mv=%b md=%h mc=%0d ce=%b required 0/0/0/0",
               mask_valid, mask_data, mask_count, cfg_err);
    end else n_pass++;
    #3 rst_n = 1'b1;
    tick();
    n_total++;
    if (vox_ready !== 1'b1) $display("FAIL reset_vox_ready: got %b required 1", vox_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    cfg_write(15'd5, 32'h0000_0003);
    cfg_write(15'd9, 32'h8000_0000);
    cfg_write(15'd0, 32'h0000_0001);
    n_total++;
    if (cfg_err !== 1'b0) $display("FAIL basic_cfg_ok: got cfg_err=%b required 0", cfg_err);
    else n_pass++;
    send_beat(15'd5, 1'b0);
    send_beat(15'd9, 1'b1);
    // just after edge t
    n_total++;
    if (mask_valid !== 1'b0 || vox_ready !== 1'b0)
      $display("FAIL basic_t0: got mv=%b vr=%b required mv=0 vr=0", mask_valid, vox_ready);
    else n_pass++;
    tick();
    n_total++;
    if (mask_valid !== 1'b0) $display("FAIL basic_t1: got mv=%b required 0", mask_valid);
    else n_pass++;
    tick();
    n_total++;
    if (mask_valid !== 1'b1 || mask_data !== 32'h8000_0003 || mask_count !== 4'd2)
      $display("FAIL basic_t2: got mv=%b md=%h mc=%0d required 1/80000003/2",
               mask_valid, mask_data, mask_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mask_valid !== 1'b1 || mask_data !== 32'h8000_0003 || mask_count !== 4'd2)
        stable = 1'b0;
    end
    n_total++;
    if (!stable) $display("FAIL backpressure_hold: got unstable outputs md=%h mc=%0d required 80000003/2",
                          mask_data, mask_count);
    else n_pass++;
    handshake();
    n_total++;
    if (mask_valid !== 1'b0 || vox_ready !== 1'b1)
      $display("FAIL post_handshake: got mv=%b vr=%b required 0/1", mask_valid, vox_ready);
    else n_pass++;
    send_beat(15'd5, 1'b1);
    wait_mask(ok);
    n_total++;
    if (!ok || mask_data !== 32'h0000_0003 || mask_count !== 4'd1)
      $display("FAIL second_frame: got ok=%b md=%h mc=%0d required 1/00000003/1",
               ok, mask_data, mask_count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_reject_write();
    bit ok;
    send_beat(15'd9, 1'b0);
    cfg_we = 1'b1; cfg_addr = 15'd5; cfg_data = 32'hFFFF_FFFF;
    tick();
    cfg_we = 1'b0;
    n_total++;
    if (cfg_err !== 1'b1) $display("FAIL reject_accum_pulse: got %b required 1", cfg_err);
    else n_pass++;
    tick();
    n_total++;
    if (cfg_err !== 1'b0) $display("FAIL reject_accum_once: got %b required 0", cfg_err);
    else n_pass++;
    send_beat(15'd5, 1'b1);
    wait_mask(ok);
    n_total++;
    if (!ok || mask_data !== 32'h8000_0003 || mask_count !== 4'd2)
      $display("FAIL reject_accum_frame: got ok=%b md=%h mc=%0d required 1/80000003/2",
               ok, mask_data, mask_count);
    else n_pass++;
    handshake();
    // load colliding with a voxel beat in IDLE
    cfg_we = 1'b1; cfg_addr = 15'd5; cfg_data = 32'hFFFF_FFFF;
    send_beat(15'd5, 1'b1);
    cfg_we = 1'b0;
    n_total++;
    if (cfg_err !== 1'b1) $display("FAIL reject_idle_pulse: got %b required 1", cfg_err);
    else n_pass++;
    wait_mask(ok);
    n_total++;
    if (!ok || mask_data !== 32'h0000_0003 || mask_count !== 4'd1)
      $display("FAIL reject_idle_frame: got ok=%b md=%h mc=%0d required 1/00000003/1",
               ok, mask_data, mask_count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_abort();
    bit ok;
    bit seen = 1'b0;
    send_beat(15'd9, 1'b0);
    send_beat(15'd5, 1'b0);
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    n_total++;
    if (vox_ready !== 1'b1 || mask_count !== 4'd0 || mask_data !== '0)
      $display("FAIL abort_accum_clear: got vr=%b mc=%0d md=%h required 1/0/0",
               vox_ready, mask_count, mask_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (mask_valid) seen = 1'b1;
      tick();
    end
    n_total++;
    if (seen) $display("FAIL abort_no_result: got mask_valid=1 required 0");
    else n_pass++;
    send_beat(15'd5, 1'b1);
    wait_mask(ok);
    n_total++;
    if (!ok || mask_data !== 32'h0000_0003 || mask_count !== 4'd1)
      $display("FAIL abort_next_frame: got ok=%b md=%h mc=%0d required 1/00000003/1",
               ok, mask_data, mask_count);
    else n_pass++;
    handshake();
    // abort while draining
    send_beat(15'd9, 1'b1);
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mask_valid) seen = 1'b1;
      tick();
    end
    n_total++;
    if (seen || vox_ready !== 1'b1 || mask_count !== 4'd0)
      $display("FAIL abort_drain: got seen=%b vr=%b mc=%0d required 0/1/0",
               seen, vox_ready, mask_count);
    else n_pass++;
    // abort is ignored once the result is waiting
    send_beat(15'd9, 1'b1);
    wait_mask(ok);
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    n_total++;
    if (!ok || mask_valid !== 1'b1 || mask_data !== 32'h8000_0000 || mask_count !== 4'd1)
      $display("FAIL abort_done_ignored: got mv=%b md=%h mc=%0d required 1/80000000/1",
               mask_valid, mask_data, mask_count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_saturation();
    bit ok;
    for (int i = 0; i < 20; i++) send_beat(15'd0, (i == 19));
    wait_mask(ok);
    n_total++;
    if (!ok || mask_data !== 32'h0000_0001 || mask_count !== 4'd15)
      $display("FAIL saturation: got ok=%b md=%h mc=%0d required 1/00000001/15",
               ok, mask_data, mask_count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_async_reset();
    bit ok;
    send_beat(15'd9, 1'b0);
    send_beat(15'd5, 1'b0);
    n_total++;
    if (mask_count !== 4'd2 || mask_data !== 32'h8000_0000)
      $display("FAIL pre_reset_accum: got mc=%0d md=%h required 2/80000000", mask_count, mask_data);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (mask_valid !== 1'b0 || mask_data !== '0 || mask_count !== '0)
      $display("FAIL async_reset_clear: got mv=%b md=%h mc=%0d required 0/0/0",
               mask_valid, mask_data, mask_count);
    else n_pass++;
    #2 rst_n = 1'b1;
    tick();
    n_total++;
    if (vox_ready !== 1'b1 || mask_valid !== 1'b0)
      $display("FAIL async_reset_release: got vr=%b mv=%b required 1/0", vox_ready, mask_valid);
    else n_pass++;
    send_beat(15'd5, 1'b1);
    wait_mask(ok);
    n_total++;
    if (!ok || mask_data !== 32'h0000_0003 || mask_count !== 4'd1)
      $display("FAIL table_kept: got ok=%b md=%h mc=%0d required 1/00000003/1",
               ok, mask_data, mask_count);
    else n_pass++;
    handshake();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    vox_valid = 1'b0; vox_data = '0; vox_last = 1'b0;
    frame_abort = 1'b0; mask_ready = 1'b0;
    #9;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reject_write();
    test_abort();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
